// File: rtl/udp_pkg.sv
// Shared constants and types for the UDP/IP configuration loader.
// Contents: frame magic, frame length, field byte offsets, reject cause
// codes and the parser state encoding.
package udp_pkg;

    localparam logic [7:0] CFG_MAGIC       = 8'hC5;
    localparam int         CFG_FRAME_BYTES = 20;

    // Byte offsets of each field within the frame (all fields MSB first).
    localparam int OFF_MAC  = 1;
    localparam int OFF_IP   = 7;
    localparam int OFF_GW   = 11;
    localparam int OFF_MASK = 15;
    localparam int OFF_CSUM = 19;

    typedef enum logic [1:0] {
        ERR_MAGIC   = 2'd0,
        ERR_LENGTH  = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } cfg_err_e;

    typedef enum logic [1:0] {
        S_MAGIC = 2'd0,
        S_BODY  = 2'd1,
        S_CSUM  = 2'd2,
        S_DRAIN = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/udp_config_loader.sv
// Parses a 20-byte configuration frame from an 8-bit AXI-Stream, validates
// magic and checksum, and atomically commits MAC / IP / gateway / mask.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   s_axis_tdata/tvalid/tlast    incoming config bytes
//   s_axis_tready                always 1 after reset release (never stalls)
//   local_mac, local_ip,
//   gateway_ip, subnet_mask      committed configuration (DEFAULT_* until first commit)
//   cfg_update                   1-cycle pulse when new values first appear
//   cfg_error, cfg_error_code    1-cycle pulse + cause for a rejected frame
module udp_config_loader
    import udp_pkg::*;
#(
    parameter logic [47:0] DEFAULT_MAC     = 48'h02_00_00_00_00_00,
    parameter logic [31:0] DEFAULT_IP      = 32'hC0A8_0180,
    parameter logic [31:0] DEFAULT_GATEWAY = 32'hC0A8_0101,
    parameter logic [31:0] DEFAULT_MASK    = 32'hFFFF_FF00,
    parameter int          TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [47:0] local_mac,
    output logic [31:0] local_ip,
    output logic [31:0] gateway_ip,
    output logic [31:0] subnet_mask,
    output logic        cfg_update,
    output logic        cfg_error,
    output logic [1:0]  cfg_error_code
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      IDX_LAST_BODY = 5'(OFF_CSUM - 1);

    cfg_state_e        state;
    logic [4:0]        idx;
    logic [7:0]        sum;
    logic [TO_W-1:0]   idle_cnt;
    // Body bytes shift in MSB first, so after 18 bytes the vector is
    // {MAC, IP, GW, MASK} with the mask in the low 32 bits.
    logic [143:0]      shadow;
    logic              commit_p1;

    logic              hs;
    logic [7:0]        sum_next;
    logic              idle_expired;

    assign hs           = s_axis_tvalid && s_axis_tready;
    assign sum_next     = sum + s_axis_tdata;
    assign idle_expired = (idle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_MAGIC;
            s_axis_tready  <= 1'b0;
            idx            <= '0;
            sum            <= '0;
            idle_cnt       <= '0;
            shadow         <= '0;
            commit_p1      <= 1'b0;
            cfg_update     <= 1'b0;
            cfg_error      <= 1'b0;
            cfg_error_code <= ERR_MAGIC;
            local_mac      <= DEFAULT_MAC;
            local_ip       <= DEFAULT_IP;
            gateway_ip     <= DEFAULT_GATEWAY;
            subnet_mask    <= DEFAULT_MASK;
        end else begin
            s_axis_tready <= 1'b1;
            cfg_error     <= 1'b0;
            commit_p1     <= 1'b0;

            // Stage p1: checksum accepted one edge earlier -> publish shadow.
            cfg_update <= commit_p1;
            if (commit_p1) begin
                local_mac   <= shadow[143:96];
                local_ip    <= shadow[95:64];
                gateway_ip  <= shadow[63:32];
                subnet_mask <= shadow[31:0];
            end

            // Stage p0: parser.
            case (state)
                S_MAGIC: begin
                    idle_cnt <= '0;
                    if (hs) begin
                        if (s_axis_tdata == CFG_MAGIC) begin
                            idx <= 5'(OFF_MAC);
                            sum <= '0;
                            if (s_axis_tlast) begin
                                cfg_error      <= 1'b1;
                                cfg_error_code <= ERR_LENGTH;
                            end else begin
                                state <= S_BODY;
                            end
                        end else begin
                            cfg_error      <= 1'b1;
                            cfg_error_code <= ERR_MAGIC;
                            if (!s_axis_tlast)
                                state <= S_DRAIN;
                        end
                    end
                end

                S_BODY: begin
                    if (hs) begin
                        idle_cnt <= '0;
                        shadow   <= {shadow[135:0], s_axis_tdata};
                        sum      <= sum_next;
                        idx      <= idx + 5'd1;
                        if (s_axis_tlast) begin
                            cfg_error      <= 1'b1;
                            cfg_error_code <= ERR_LENGTH;
                            state          <= S_MAGIC;
                        end else if (idx == IDX_LAST_BODY) begin
                            state <= S_CSUM;
                        end
                    end else if (idle_expired) begin
                        idle_cnt       <= '0;
                        cfg_error      <= 1'b1;
                        cfg_error_code <= ERR_TIMEOUT;
                        state          <= S_DRAIN;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end

                S_CSUM: begin
                    if (hs) begin
                        idle_cnt <= '0;
                        if (!s_axis_tlast) begin
                            cfg_error      <= 1'b1;
                            cfg_error_code <= ERR_LENGTH;
                            state          <= S_DRAIN;
                        end else if (sum_next != 8'h00) begin
                            cfg_error      <= 1'b1;
                            cfg_error_code <= ERR_CSUM;
                            state          <= S_MAGIC;
                        end else begin
                            commit_p1 <= 1'b1;
                            state     <= S_MAGIC;
                        end
                    end else if (idle_expired) begin
                        idle_cnt       <= '0;
                        cfg_error      <= 1'b1;
                        cfg_error_code <= ERR_TIMEOUT;
                        state          <= S_DRAIN;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end

                S_DRAIN: begin
                    idle_cnt <= '0;
                    if (hs && s_axis_tlast)
                        state <= S_MAGIC;
                end

                default: state <= S_MAGIC;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_config_loader.sv
// Directed bench for udp_config_loader: table of whole frames with expected
// outcome, plus hand-written timeout, back-to-back and mid-frame reset cases.
module tb_udp_config_loader;

    localparam int TO = 32;
    localparam logic [47:0] D_MAC  = 48'h02_00_00_00_00_00;
    localparam logic [31:0] D_IP   = 32'hC0A8_0180;
    localparam logic [31:0] D_GW   = 32'hC0A8_0101;
    localparam logic [31:0] D_MASK = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [31:0] gateway_ip;
    logic [31:0] subnet_mask;
    logic        cfg_update;
    logic        cfg_error;
    logic [1:0]  cfg_error_code;

    udp_config_loader #(
        .DEFAULT_MAC     (D_MAC),
        .DEFAULT_IP      (D_IP),
        .DEFAULT_GATEWAY (D_GW),
        .DEFAULT_MASK    (D_MASK),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .local_mac      (local_mac),
        .local_ip       (local_ip),
        .gateway_ip     (gateway_ip),
        .subnet_mask    (subnet_mask),
        .cfg_update     (cfg_update),
        .cfg_error      (cfg_error),
        .cfg_error_code (cfg_error_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  magic;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [31:0] gw;
        logic [31:0] mask;
        logic [7:0]  csum;
        int          nbytes;
        int          tlast_idx;
        bit          exp_upd;
        bit          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;

    // Cycle bookkeeping: cyc counts rising edges; the monitor samples on falling edges.
    int cyc = 0;
    int hs_cyc = -100;
    int upd_cyc = -100;
    int err_cyc = -100;
    int upd_cnt = 0;
    int err_cnt = 0;
    logic [1:0] err_code_seen = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) hs_cyc = cyc;
        if (cfg_update) begin
            upd_cnt = upd_cnt + 1;
            upd_cyc = cyc;
        end
        if (cfg_error) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
            err_code_seen = cfg_error_code;
        end
    end

    // Expected committed configuration.
    logic [47:0] m_mac;
    logic [31:0] m_ip, m_gw, m_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run = n_run + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " mac"},  64'(local_mac),   64'(m_mac));
        check({tag, " ip"},   64'(local_ip),    64'(m_ip));
        check({tag, " gw"},   64'(gateway_ip),  64'(m_gw));
        check({tag, " mask"}, 64'(subnet_mask), 64'(m_mask));
    endtask

    function automatic logic [7:0] frame_byte(input vec_t v, input int i);
        logic [143:0] body;
        body = {v.mac, v.ip, v.gw, v.mask};
        if (i == 0)       return v.magic;
        else if (i <= 18) return body[143 - 8*(i-1) -: 8];
        else if (i == 19) return v.csum;
        else              return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends a frame; when stall_after >= 0 the bus idles stall_cyc cycles after
    // that byte. stall_cyc_start is the edge count at which that byte was taken.
    task automatic send_frame(input vec_t v, input int stall_after, input int stall_cyc,
                              output int stall_cyc_start);
        stall_cyc_start = -1;
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(frame_byte(v, i), i == v.tlast_idx);
            if (i == stall_after) begin
                stall_cyc_start = cyc;
                go_idle(stall_cyc);
            end
        end
    endtask

    vec_t vecs [11];
    vec_t fa, fb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int u0, e0, p;

        reset_n       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        m_mac = D_MAC; m_ip = D_IP; m_gw = D_GW; m_mask = D_MASK;

        // Frame A and B with hand-computed checksums (0x16 -> EA, 0xE5 -> 1B).
        fa = '{8'hC5, 48'h02_11_22_33_44_55, 32'h0A00_0002, 32'h0A00_0001, 32'hFFFF_0000,
               8'hEA, 20, 19, 1'b1, 1'b0, 2'd0};
        fb = '{8'hC5, 48'h02_AA_BB_CC_DD_EE, 32'hC0A8_0A05, 32'hC0A8_0A01, 32'hFFFF_FF00,
               8'h1B, 20, 19, 1'b1, 1'b0, 2'd0};

        vecs[0] = fa;
        vecs[1] = fa; vecs[1].csum = 8'hEB; vecs[1].exp_upd = 0; vecs[1].exp_err = 1; vecs[1].exp_code = 2'd2;
        vecs[2] = fb;
        vecs[3] = fa; vecs[3].nbytes = 11; vecs[3].tlast_idx = 10;
        vecs[3].exp_upd = 0; vecs[3].exp_err = 1; vecs[3].exp_code = 2'd1;
        vecs[4] = fa;
        vecs[5] = fa; vecs[5].magic = 8'hAA; vecs[5].exp_upd = 0; vecs[5].exp_err = 1; vecs[5].exp_code = 2'd0;
        vecs[6] = fb;
        vecs[7] = fa; vecs[7].nbytes = 1; vecs[7].tlast_idx = 0;
        vecs[7].exp_upd = 0; vecs[7].exp_err = 1; vecs[7].exp_code = 2'd1;
        vecs[8] = fa;
        vecs[9] = fb; vecs[9].nbytes = 21; vecs[9].tlast_idx = 20;
        vecs[9].exp_upd = 0; vecs[9].exp_err = 1; vecs[9].exp_code = 2'd1;
        vecs[10] = fb;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset tready", 64'(s_axis_tready), 64'd0);
        check("reset update", 64'(cfg_update), 64'd0);
        check("reset error",  64'(cfg_error), 64'd0);
        check("reset code",   64'(cfg_error_code), 64'd0);
        check_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready after release", 64'(s_axis_tready), 64'd1);
        go_idle(3);
        check("no pulses after reset", 64'(upd_cnt + err_cnt), 64'd0);

        // Table of whole frames.
        for (int k = 0; k < 11; k++) begin
            u0 = upd_cnt;
            e0 = err_cnt;
            send_frame(vecs[k], -1, 0, p);
            go_idle(4);
            check($sformatf("v%0d update count", k), 64'(upd_cnt - u0), 64'(vecs[k].exp_upd));
            check($sformatf("v%0d error count", k),  64'(err_cnt - e0), 64'(vecs[k].exp_err));
            if (vecs[k].exp_err)
                check($sformatf("v%0d error code", k), 64'(err_code_seen), 64'(vecs[k].exp_code));
            if (vecs[k].exp_upd) begin
                check($sformatf("v%0d update latency", k), 64'(upd_cyc - hs_cyc), 64'd2);
                m_mac = vecs[k].mac; m_ip = vecs[k].ip; m_gw = vecs[k].gw; m_mask = vecs[k].mask;
            end
            if (vecs[k].exp_err && vecs[k].exp_code != 2'd0 && vecs[k].nbytes <= 20)
                check($sformatf("v%0d error latency", k), 64'(err_cyc - hs_cyc), 64'd1);
            check_outputs($sformatf("v%0d", k));
        end

        // Stall of TO-1 idle cycles mid-body: not a timeout, frame commits.
        u0 = upd_cnt; e0 = err_cnt;
        send_frame(fa, 4, TO - 1, p);
        go_idle(4);
        check("near-timeout update", 64'(upd_cnt - u0), 64'd1);
        check("near-timeout no error", 64'(err_cnt - e0), 64'd0);
        m_mac = fa.mac; m_ip = fa.ip; m_gw = fa.gw; m_mask = fa.mask;
        check_outputs("near-timeout");

        // Stall of TO idle cycles after byte 7: timeout, rest drained.
        u0 = upd_cnt; e0 = err_cnt;
        send_frame(fb, 7, TO, p);
        go_idle(4);
        check("timeout error count", 64'(err_cnt - e0), 64'd1);
        check("timeout code", 64'(err_code_seen), 64'd3);
        check("timeout latency", 64'(err_cyc - p), 64'(TO));
        check("timeout no update", 64'(upd_cnt - u0), 64'd0);
        check_outputs("timeout");

        // Back-to-back frames, no gap: two updates, second frame wins.
        u0 = upd_cnt; e0 = err_cnt;
        for (int i = 0; i < 20; i++) send_byte(frame_byte(fb, i), i == 19);
        for (int i = 0; i < 20; i++) send_byte(frame_byte(fa, i), i == 19);
        go_idle(4);
        check("b2b update count", 64'(upd_cnt - u0), 64'd2);
        check("b2b no error", 64'(err_cnt - e0), 64'd0);
        check_outputs("b2b");

        // Third frame interrupted by reset at byte 12.
        u0 = upd_cnt;
        for (int i = 0; i < 12; i++) send_byte(frame_byte(fb, i), 1'b0);
        s_axis_tdata = frame_byte(fb, 12);
        reset_n = 1'b0;
        #1;
        m_mac = D_MAC; m_ip = D_IP; m_gw = D_GW; m_mask = D_MASK;
        check_outputs("mid-frame reset");
        check("mid-frame reset tready", 64'(s_axis_tready), 64'd0);
        go_idle(2);
        reset_n = 1'b1;
        go_idle(4);
        check("after reset no update", 64'(upd_cnt - u0), 64'd0);
        check_outputs("after reset");

        // Loader works normally after the reset.
        send_frame(fb, -1, 0, p);
        go_idle(4);
        check("post-reset update", 64'(upd_cnt - u0), 64'd1);
        m_mac = fb.mac; m_ip = fb.ip; m_gw = fb.gw; m_mask = fb.mask;
        check_outputs("post-reset");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
